// File: rtl/zero_delay_ram.sv
// Word-organised data memory: combinational read, synchronous write, words 0/1 mapped to I/O.
// Optional write-through forwarding on RAMOut when ZERO_DELAY_RAM_WRITE_FORWARD_EN is defined.
module zero_delay_ram #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RAMAddrSize-1:0] RAMAddr,
    input  logic [dataW-1:0]       DataIn,
    input  logic                   WriteControl,
    input  logic [dataW-1:0]       InpWord1,
    input  logic [dataW-1:0]       InpWord2,
    output logic [dataW-1:0]       RAMOut,
    output logic [dataW-1:0]       OutWord1,
    output logic [dataW-1:0]       OutWord2
);

    localparam int          WordW = RAMAddrSize - 2;
    localparam int unsigned Depth = 2 ** WordW;

    logic [WordW-1:0] word;
    logic [dataW-1:0] mem_q [Depth];
    logic [dataW-1:0] out1_q, out1_d;
    logic [dataW-1:0] out2_q, out2_d;
    logic             mem_we;
    logic [dataW-1:0] rd_data;
    logic             unused_byte_sel;

    assign word            = RAMAddr[RAMAddrSize-1:2];
    assign unused_byte_sel = ^RAMAddr[1:0];

    always_comb begin
        out1_d = out1_q;
        out2_d = out2_q;
        mem_we = 1'b0;
        if (WriteControl) begin
            if (word == WordW'(0)) begin
                out1_d = DataIn;
            end else if (word == WordW'(1)) begin
                out2_d = DataIn;
            end else begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out1_q <= '0;
            out2_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i[WordW-1:0]] <= '0;
            end
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            if (mem_we) begin
                mem_q[word] <= DataIn;
            end
        end
    end

    // Words 0/1 always read the external inputs; forwarding only applies to storage words.
    always_comb begin
        rd_data = mem_q[word];
        if (word == WordW'(0)) begin
            rd_data = InpWord1;
        end else if (word == WordW'(1)) begin
            rd_data = InpWord2;
        end
`ifdef ZERO_DELAY_RAM_WRITE_FORWARD_EN
        else if (WriteControl) begin
            rd_data = DataIn;
        end
`endif
    end

    assign RAMOut   = rd_data;
    assign OutWord1 = out1_q;
    assign OutWord2 = out2_q;

endmodule

// File: tb/tb_zero_delay_ram.sv
// Randomized bench for zero_delay_ram against an array-based memory model, plus directed literal checks.
module tb_zero_delay_ram;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  RAMAddr;
    logic [31:0] DataIn;
    logic        WriteControl;
    logic [31:0] InpWord1;
    logic [31:0] InpWord2;
    logic [31:0] RAMOut;
    logic [31:0] OutWord1;
    logic [31:0] OutWord2;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [64];
    logic [31:0] model_o1, model_o2;
    bit          model_valid = 1'b0;

    zero_delay_ram #(.dataW(32), .RAMAddrSize(8)) dut (
        .clock(clock),
        .reset(reset),
        .RAMAddr(RAMAddr),
        .DataIn(DataIn),
        .WriteControl(WriteControl),
        .InpWord1(InpWord1),
        .InpWord2(InpWord2),
        .RAMOut(RAMOut),
        .OutWord1(OutWord1),
        .OutWord2(OutWord2)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expected_read();
        int w;
        w = int'(RAMAddr) / 4;
        if (w == 0) return InpWord1;
        if (w == 1) return InpWord2;
`ifdef ZERO_DELAY_RAM_WRITE_FORWARD_EN
        if (WriteControl) return DataIn;
`endif
        return model_mem[w];
    endfunction

    // Reference model: the memory as a plain array updated from the sampled inputs each edge.
    always @(posedge clock) begin
        int w;
        w = int'(RAMAddr) / 4;
        if (reset) begin
            for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
            model_o1    = 32'd0;
            model_o2    = 32'd0;
            model_valid = 1'b1;
        end else if (WriteControl) begin
            if (w == 0)      model_o1 = DataIn;
            else if (w == 1) model_o2 = DataIn;
            else             model_mem[w] = DataIn;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("cyc_RAMOut", RAMOut, expected_read());
            check("cyc_OutWord1", OutWord1, model_o1);
            check("cyc_OutWord2", OutWord2, model_o2);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        RAMAddr      = 8'd0;
        DataIn       = 32'd0;
        WriteControl = 1'b0;
        InpWord1     = 32'd87;
        InpWord2     = 32'd0;
        step();
        reset = 1'b0;
        @(negedge clock); #1;
        check("rst_read_inp1", RAMOut, 32'd87);
        check("rst_out1", OutWord1, 32'd0);
        check("rst_out2", OutWord2, 32'd0);

        RAMAddr = 8'd0; DataIn = 32'd55; WriteControl = 1'b1;
        step();
        check("io_out1_written", OutWord1, 32'd55);
        check("io_read_still_inp1", RAMOut, 32'd87);
        RAMAddr = 8'd8;
        step();
        WriteControl = 1'b0;
        #1;
        check("mem2_read", RAMOut, 32'd55);

        RAMAddr = 8'd64; DataIn = 32'd90; WriteControl = 1'b1;
        #1;
`ifdef ZERO_DELAY_RAM_WRITE_FORWARD_EN
        check("fwd_before_edge", RAMOut, 32'd90);
`else
        check("nofwd_before_edge", RAMOut, 32'd0);
`endif
        step();
        RAMAddr = 8'd68; DataIn = 32'd91;
        step();
        WriteControl = 1'b0;
        RAMAddr = 8'd64;
        #1;
        check("read64", RAMOut, 32'd90);
        RAMAddr = 8'd68;
        #1;
        check("read68", RAMOut, 32'd91);

        RAMAddr = 8'd68; DataIn = 32'hDEADBEEF; WriteControl = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; WriteControl = 1'b0;
        #1;
        check("rst_beats_write", RAMOut, 32'd0);
        check("rst_out1_clear", OutWord1, 32'd0);
        check("rst_out2_clear", OutWord2, 32'd0);
        RAMAddr = 8'd64;
        #1;
        check("rst_clears_mem", RAMOut, 32'd0);

        InpWord2 = 32'h1234; RAMAddr = 8'd4;
        #1;
        check("read_inp2", RAMOut, 32'h1234);
        DataIn = 32'd7; WriteControl = 1'b1;
        step();
        WriteControl = 1'b0;
        #1;
        check("io_out2_written", OutWord2, 32'd7);
        check("io_read_still_inp2", RAMOut, 32'h1234);
        RAMAddr = 8'd5;
        #1;
        check("unaligned_inp2", RAMOut, 32'h1234);
        RAMAddr = 8'd255;
        #1;
        check("top_word_zero", RAMOut, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            RAMAddr      = 8'($urandom_range(0, 255));
            DataIn       = $urandom;
            WriteControl = ($urandom_range(0, 1) == 1);
            reset        = ($urandom_range(0, 99) == 0);
            InpWord1     = $urandom;
            InpWord2     = $urandom;
        end
        step();
        reset = 1'b0; WriteControl = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
